// File: rtl/cfg_switch_box.sv
// rtl/cfg_switch_box.sv - directional switch box with scan-loaded, commit-validated routing config
module cfg_switch_box #(
  parameter int W       = 8,
  parameter int REG_OUT = 1,
  parameter int WILTON  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] north_in,
  input  logic [W-1:0] east_in,
  input  logic [W-1:0] south_in,
  input  logic [W-1:0] west_in,
  output logic [W-1:0] north_out,
  output logic [W-1:0] east_out,
  output logic [W-1:0] south_out,
  output logic [W-1:0] west_out,
  input  logic         cfg_en,
  input  logic         cfg_in,
  output logic         cfg_out,
  input  logic         cfg_commit,
  output logic         cfg_ready,
  output logic         cfg_ok,
  output logic         cfg_err
);

  localparam int CFG_BITS = 8 * W;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_READY} cfg_state_e;

  cfg_state_e          state_q, state_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

  // Commit has priority over shift; a shift in the commit cycle is dropped.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    if (cfg_commit) begin
      if (state_q == ST_READY) begin
        active_d = shadow_q;
        cnt_d    = '0;
        state_d  = ST_EMPTY;
        ok_d     = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (cfg_en) begin
      shadow_d = {cfg_in, shadow_q[CFG_BITS-1:1]};
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
      state_d = (cnt_d == CNT_FULL) ? ST_READY : ST_FILLING;
    end
  end

  assign cfg_out   = shadow_q[0];
  assign cfg_ready = (cnt_q == CNT_FULL);
  assign cfg_ok    = ok_q;
  assign cfg_err   = err_q;

  logic [4*W-1:0] in_all;
  logic [4*W-1:0] route;
  logic [4*W-1:0] out_v;

  assign in_all = {west_in, south_in, east_in, north_in};

  for (genvar s = 0; s < 4; s++) begin : g_side
    for (genvar i = 0; i < W; i++) begin : g_trk
      localparam int CW_SRC = ((s + 1) % 4) * W + ((WILTON != 0) ? (i + 1) % W : i);
      localparam int OP_SRC = ((s + 2) % 4) * W + i;
      localparam int CC_SRC = ((s + 3) % 4) * W + ((WILTON != 0) ? (i + W - 1) % W : i);
      logic [1:0] sel;
      assign sel = active_q[2*(s*W+i) +: 2];
      assign route[s*W+i] = (sel == 2'b01) ? in_all[CW_SRC] :
                            (sel == 2'b10) ? in_all[OP_SRC] :
                            (sel == 2'b11) ? in_all[CC_SRC] : 1'b0;
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic [4*W-1:0] out_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_q <= '0;
      else        out_q <= route;
    end
    assign out_v = out_q;
  end else begin : g_comb
    assign out_v = route;
  end

  assign north_out = out_v[0*W +: W];
  assign east_out  = out_v[1*W +: W];
  assign south_out = out_v[2*W +: W];
  assign west_out  = out_v[3*W +: W];

endmodule
